// File: rtl/pin_ser_pkg.sv
// pin_ser_pkg: shared state type, beat-count helper and default sizes for pin_word_serializer
package pin_ser_pkg;
    typedef enum logic {IDLE, SEND} state_t;
    localparam int DEF_WIDTH = 513;
    localparam int DEF_BEAT = 32;
    function automatic int nbeats(input int width, input int beat);
        return (width + beat - 1) / beat;
    endfunction
endpackage

// File: rtl/pin_word_serializer.sv
// pin_word_serializer: accepts one wide word per handshake and emits it as LSB-first beats with a last flag
// Optional even parity output out_par when PIN_SER_PARITY_EN is defined.
module pin_word_serializer
    import pin_ser_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int BEAT = DEF_BEAT,
    localparam int NBEATS = nbeats(WIDTH, BEAT),
    localparam int IDXW = NBEATS > 1 ? $clog2(NBEATS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BEAT-1:0]  out_data,
    output logic             out_last,
    output logic [IDXW-1:0]  out_idx,
    output logic [15:0]      words_done
`ifdef PIN_SER_PARITY_EN
    ,
    output logic             out_par
`endif
);
    localparam int SHW = NBEATS * BEAT;
    localparam logic [IDXW-1:0] LAST = IDXW'(NBEATS - 1);
    state_t state, state_d;
    logic [SHW-1:0] shreg, shreg_d;
    logic [IDXW-1:0] idx_d;
    logic load, take;
    always_comb begin
        out_valid = state == SEND;
        out_data = shreg[BEAT-1:0];
        out_last = out_valid && out_idx == LAST;
        take = out_valid && out_ready;
        in_ready = !out_valid || (out_last && out_ready);
        load = in_valid && in_ready;
        state_d = load ? SEND : (take && out_last) ? IDLE : state;
        shreg_d = load ? SHW'(in_data) : (take && !out_last) ? shreg >> BEAT : shreg;
        idx_d = load ? '0 : (take && !out_last) ? out_idx + IDXW'(1) : out_idx;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            shreg <= '0;
            out_idx <= '0;
            words_done <= '0;
        end else begin
            state <= state_d;
            shreg <= shreg_d;
            out_idx <= idx_d;
            words_done <= words_done + 16'(take && out_last);
        end
    end
`ifdef PIN_SER_PARITY_EN
    // Parity tracks the next front beat so it changes in the same cycle as out_data.
    always_ff @(posedge clk) out_par <= rst ? 1'b0 : ^shreg_d[BEAT-1:0];
`endif
endmodule
